// File: rtl/slow_pkg.sv
// Shared state encodings, counter width and hit decode for the slow-access sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package slow_pkg;

  localparam int CNT_W = 4;

  // Registered FSM states; the unused code 2'd3 is treated as IDLE.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SLOW = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  // Chip-select / enable bit order: {Snd, SCSI, SCC, IWM, VIA, IACK}
  typedef logic [5:0] csVec_t;

  function automatic logic slowHit(input logic bact, input csVec_t cs, input csVec_t en);
    return bact & (|(cs & en));
  endfunction

endpackage

// File: rtl/slow_tick_div.sv
// Hold-time prescaler: divides CLK by TICKDIV while enabled, flags the last count as Tick.
// Latency: Tick is combinational from the registered count; count advances each enabled cycle.
// Backpressure: none; Clr or a dropped En returns the count to 0 on the next edge.
module slow_tick_div
  import slow_pkg::*;
#(
  parameter int TICKDIV = 16
) (
  input  logic CLK,
  input  logic nPOR,
  input  logic En,
  input  logic Clr,
  output logic Tick
);

  localparam int PW = $clog2(TICKDIV);
  localparam logic [PW-1:0] LAST = PW'(TICKDIV - 1);

  logic [PW-1:0] presc;

  assign Tick = (presc == LAST);

  // Count 0..TICKDIV-1 only while enabled; parked at 0 otherwise so each hold starts aligned
  always_ff @(posedge CLK) begin
    if (!nPOR) begin
      presc <= '0;
    end else if (Clr || !En || Tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

endmodule

// File: rtl/slow_access_seq.sv
// Slow-access sequencer: qualified peripheral hits force slow mode, held SlowTimeout ticks after the access.
// Latency: SlowReq/SlowBusy rise at the edge sampling a hit; hold ends SlowTimeout*TICKDIV cycles after BACT falls.
// Backpressure: none; new hits during HOLD re-enter SLOW, SlowGate follows SlowClockGate combinationally.
module slow_access_seq
  import slow_pkg::*;
#(
  parameter int TICKDIV = 16
) (
  input  logic       CLK,
  input  logic       nPOR,
  input  logic       BACT,
  input  logic       IACKCS,
  input  logic       VIACS,
  input  logic       IWMCS,
  input  logic       SCCCS,
  input  logic       SCSICS,
  input  logic       SndCS,
  input  logic       SlowIACK,
  input  logic       SlowVIA,
  input  logic       SlowIWM,
  input  logic       SlowSCC,
  input  logic       SlowSCSI,
  input  logic       SlowSnd,
  input  logic       SlowClockGate,
  input  logic [3:0] SlowTimeout,
  output logic       SlowReq,
  output logic       SlowGate,
  output logic       SlowBusy
);

  logic [1:0]       state;
  logic [1:0]       stateNxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNxt;
  logic             hit;
  logic             tick;
  logic             divEn;
  logic             divClr;

  assign hit = slowHit(BACT,
                       {SndCS, SCSICS, SCCCS, IWMCS, VIACS, IACKCS},
                       {SlowSnd, SlowSCSI, SlowSCC, SlowIWM, SlowVIA, SlowIACK});

  // Prescaler runs only while holding with no fresh hit; restarts from 0 on HOLD entry
  assign divEn  = (state == HOLD) && !hit;
  assign divClr = (state == SLOW) && !BACT;

  slow_tick_div #(.TICKDIV(TICKDIV)) uTickDiv (
    .CLK  (CLK),
    .nPOR (nPOR),
    .En   (divEn),
    .Clr  (divClr),
    .Tick (tick)
  );

  // Next-state and hold-count decode; a hit in HOLD beats the final tick
  always_comb begin
    stateNxt = state;
    cntNxt   = cnt;
    case (state)
      SLOW: begin
        if (!BACT) begin
          if (SlowTimeout == 4'd0) begin
            stateNxt = IDLE;
          end else begin
            stateNxt = HOLD;
            cntNxt   = CNT_W'(SlowTimeout);
          end
        end
      end
      HOLD: begin
        if (hit) begin
          stateNxt = SLOW;
          cntNxt   = '0;
        end else if (tick) begin
          if (cnt <= CNT_W'(1)) begin
            stateNxt = IDLE;
            cntNxt   = '0;
          end else begin
            cntNxt = cnt - CNT_W'(1);
          end
        end
      end
      default: begin
        // IDLE, and the unused code folds back into IDLE
        stateNxt = hit ? SLOW : IDLE;
      end
    endcase
  end

  // State and hold-count registers; reset wins over any in-flight sequence
  always_ff @(posedge CLK) begin
    if (!nPOR) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNxt;
      cnt   <= cntNxt;
    end
  end

  assign SlowReq  = (state == SLOW) || (state == HOLD);
  assign SlowBusy = (state == SLOW);
  assign SlowGate = SlowReq & SlowClockGate;

endmodule

// File: tb/tb_slow_access_seq.sv
// Bench for slow_access_seq with TICKDIV=4: table of per-phase stimulus records with held-cycle counts.
// Latency: expected {SlowReq,SlowBusy,SlowGate} queued at drive time, checked 1ns after each edge.
// Backpressure: n/a.
module tb_slow_access_seq;

  localparam int TICKDIV = 4;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] VIA  = 6'b000010;
  localparam logic [5:0] IWM  = 6'b000100;
  localparam logic [5:0] SCC  = 6'b001000;
  localparam logic [5:0] SCSI = 6'b010000;
  localparam logic [5:0] ALL  = 6'b111111;

  logic       CLK;
  logic       nPOR;
  logic       BACT;
  logic       IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCS;
  logic       SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
  logic       SlowClockGate;
  logic [3:0] SlowTimeout;
  logic       SlowReq, SlowGate, SlowBusy;

  typedef struct {
    logic       nPor;
    logic       bact;
    logic [5:0] cs;
    logic [5:0] en;
    logic       gate;
    logic [3:0] tmo;
    int         n;
    logic [2:0] exp;   // {SlowReq, SlowBusy, SlowGate}
  } vec_t;

  typedef struct {
    logic [2:0] exp;
    int         idx;
    int         cyc;
  } sb_t;

  vec_t vecs[$];
  sb_t  sbq[$];

  int numVec  = 0;
  int numMiss = 0;

  slow_access_seq #(.TICKDIV(TICKDIV)) dut (
    .CLK           (CLK),
    .nPOR          (nPOR),
    .BACT          (BACT),
    .IACKCS        (IACKCS),
    .VIACS         (VIACS),
    .IWMCS         (IWMCS),
    .SCCCS         (SCCCS),
    .SCSICS        (SCSICS),
    .SndCS         (SndCS),
    .SlowIACK      (SlowIACK),
    .SlowVIA       (SlowVIA),
    .SlowIWM       (SlowIWM),
    .SlowSCC       (SlowSCC),
    .SlowSCSI      (SlowSCSI),
    .SlowSnd       (SlowSnd),
    .SlowClockGate (SlowClockGate),
    .SlowTimeout   (SlowTimeout),
    .SlowReq       (SlowReq),
    .SlowGate      (SlowGate),
    .SlowBusy      (SlowBusy)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic addV(input logic np, input logic b, input logic [5:0] cs, input logic [5:0] en,
                      input logic g, input logic [3:0] t, input int n, input logic [2:0] e);
    vec_t v;
    v.nPor = np; v.bact = b; v.cs = cs; v.en = en;
    v.gate = g;  v.tmo = t;  v.n = n;   v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    nPOR          = v.nPor;
    BACT          = v.bact;
    {SndCS, SCSICS, SCCCS, IWMCS, VIACS, IACKCS}             = v.cs;
    {SlowSnd, SlowSCSI, SlowSCC, SlowIWM, SlowVIA, SlowIACK} = v.en;
    SlowClockGate = v.gate;
    SlowTimeout   = v.tmo;
  endtask

  task automatic check(input string name, input logic [2:0] got, input logic [2:0] want);
    numVec++;
    if (got !== want) begin
      numMiss++;
      $display("FAIL %s {Req,Busy,Gate} got %b want %b", name, got, want);
    end
  endtask

  // Apply records lo..hi-1; each record's expectation holds for each of its n cycles
  task automatic applyRange(input int lo, input int hi);
    sb_t s;
    for (int i = lo; i < hi; i++) begin
      drive(vecs[i]);
      for (int c = 0; c < vecs[i].n; c++) begin
        s.exp = vecs[i].exp;
        s.idx = i;
        s.cyc = c;
        sbq.push_back(s);
        @(posedge CLK);
        #1;
        s = sbq.pop_front();
        check($sformatf("vec%0d.cyc%0d", s.idx, s.cyc), {SlowReq, SlowBusy, SlowGate}, s.exp);
      end
    end
  endtask

  initial begin
    int m1, m2, m3, m4, m5a, m5b, m6a, m6b;

    // Reset held with a qualified access pending
    addV(0, 1, VIA,  VIA,        1, 3, 2,  3'b000);
    m1 = vecs.size();
    // VIA hit, 5 busy cycles, 12-cycle hold, then idle
    addV(1, 1, VIA,  ALL,        1, 3, 5,  3'b111);
    addV(1, 0, NONE, ALL,        1, 3, 12, 3'b101);
    addV(1, 0, NONE, ALL,        1, 3, 2,  3'b000);
    m2 = vecs.size();
    // VIA disabled: ignored; SCC hit with zero timeout drops right after BACT falls
    addV(1, 1, VIA,  6'b111101,  1, 0, 3,  3'b000);
    addV(1, 0, NONE, ALL,        1, 0, 1,  3'b000);
    addV(1, 1, SCC,  ALL,        1, 0, 2,  3'b111);
    addV(1, 0, NONE, ALL,        1, 0, 2,  3'b000);
    m3 = vecs.size();
    // Timeout 1: last hold cycle has tick pending; SCSI hit then wins, next hold reloads with 2
    addV(1, 1, SCSI, ALL,        1, 1, 2,  3'b111);
    addV(1, 0, NONE, ALL,        1, 1, 4,  3'b101);
    addV(1, 1, SCSI, ALL,        1, 1, 2,  3'b111);
    addV(1, 0, NONE, ALL,        1, 2, 8,  3'b101);
    addV(1, 0, NONE, ALL,        1, 2, 2,  3'b000);
    m4 = vecs.size();
    // Hold with timeout 3; gate dropped by hand partway through
    addV(1, 1, VIA,  ALL,        1, 3, 2,  3'b111);
    addV(1, 0, NONE, ALL,        1, 3, 4,  3'b101);
    m5a = vecs.size();
    // Rest of that hold: timeout rewritten to 1 and an unqualified IWM access change nothing
    addV(1, 0, NONE, ALL,        0, 1, 4,  3'b100);
    addV(1, 1, IWM,  6'b111011,  0, 1, 4,  3'b100);
    addV(1, 0, NONE, ALL,        0, 1, 2,  3'b000);
    m5b = vecs.size();
    // Reset in HOLD with Cnt=2 and prescaler mid-count
    addV(1, 1, VIA,  ALL,        1, 3, 2,  3'b111);
    addV(1, 0, NONE, ALL,        1, 3, 6,  3'b101);
    addV(0, 0, NONE, ALL,        1, 3, 1,  3'b000);
    m6a = vecs.size();
    // After release: a fresh 1-unit hold must last exactly TICKDIV cycles
    addV(1, 0, NONE, ALL,        1, 3, 2,  3'b000);
    addV(1, 1, VIA,  ALL,        1, 1, 1,  3'b111);
    addV(1, 0, NONE, ALL,        1, 1, 4,  3'b101);
    addV(1, 0, NONE, ALL,        1, 1, 2,  3'b000);
    m6b = vecs.size();

    applyRange(0, m1);
    applyRange(m1, m2);
    applyRange(m2, m3);
    applyRange(m3, m4);
    applyRange(m4, m5a);

    // Mid-cycle gate clear while holding: SlowGate falls without waiting for an edge
    SlowClockGate = 1'b0;
    #1;
    check("gate_drop_live", {SlowReq, SlowBusy, SlowGate}, 3'b100);

    applyRange(m5a, m5b);
    applyRange(m5b, m6a);

    // Prescaler must be parked at 0 right after reset hit mid-hold
    numVec++;
    if (dut.uTickDiv.presc !== '0) begin
      numMiss++;
      $display("FAIL presc_after_reset got %0d want 0", dut.uTickDiv.presc);
    end

    applyRange(m6a, m6b);

    $display("== %0d vectors applied, %0d miscompares ==", numVec, numMiss);
    $finish;
  end

endmodule
